// File: rtl/cond_wait_pkg.sv
// Shared types and constants for the ordered condition-wait engine.
package cond_wait_pkg;

  localparam int unsigned NUM_STEPS = 7;

  typedef logic [2:0] step_idx_t;

  localparam step_idx_t LAST_STEP = step_idx_t'(NUM_STEPS - 1);

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StDone = 2'd2;
  localparam state_t StErr  = 2'd3;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

endpackage

// File: rtl/cond_wait_eval.sv
// Combinational evaluator: is condition idx true on the given signed operands.
module cond_wait_eval
  import cond_wait_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  step_idx_t           idx,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  output logic                cond_true
);

  localparam logic signed [W-1:0] KOne   = W'(1);
  localparam logic signed [W-1:0] KTwo   = W'(2);
  localparam logic signed [W-1:0] KThree = W'(3);
  localparam logic signed [W-1:0] KZero  = '0;

  // One extra bit so a+b never wraps before the compare against c.
  logic signed [W:0] a_ext;
  logic signed [W:0] b_ext;
  logic signed [W:0] c_ext;
  logic signed [W:0] sum;

  always_comb begin
    a_ext = {a[W-1], a};
    b_ext = {b[W-1], b};
    c_ext = {c[W-1], c};
    sum   = a_ext + b_ext;
  end

  always_comb begin
    cond_true = 1'b0;
    case (idx)
      3'd0:    cond_true = (a == KTwo);
      3'd1:    cond_true = (a < KTwo);
      3'd2:    cond_true = (a == KZero);
      3'd3:    cond_true = (a > KOne) && (a < KThree);
      3'd4:    cond_true = (b > a);
      3'd5:    cond_true = (sum < c_ext);
      3'd6:    cond_true = (a < b) && (b > c);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_wait_seq.sv
// Ordered level-sensitive wait engine: releases seven conditions in turn on
// registered variables a/b/c, with a per-step timeout.
module cond_wait_seq
  import cond_wait_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd_valid,
  input  logic [1:0]          upd_sel,
  input  logic signed [W-1:0] upd_data,
  input  logic                start,
  output logic                busy,
  output logic                step_valid,
  output logic [2:0]          step_idx,
  output logic                done,
  output logic                timeout_err,
  output logic signed [W-1:0] a_q,
  output logic signed [W-1:0] b_q,
  output logic signed [W-1:0] c_q
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  logic signed [W-1:0] a_d, b_d, c_d;
  state_t              state_q, state_d;
  step_idx_t           idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                cond_true;

  cond_wait_eval #(
    .W (W)
  ) u_eval (
    .idx       (idx_q),
    .a         (a_q),
    .b         (b_q),
    .c         (c_q),
    .cond_true (cond_true)
  );

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (upd_valid) begin
      case (upd_sel)
        SEL_A:   a_d = upd_data;
        SEL_B:   b_d = upd_data;
        SEL_C:   c_d = upd_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StWait;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      StWait: begin
        if (cond_true) begin
          timer_d = '0;
          if (idx_q == LAST_STEP) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + step_idx_t'(1);
          end
        end else if (timer_q == TimerLast) begin
          // idx stays put so the failing step remains visible.
          state_d = StErr;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      state_q <= StIdle;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    busy        = (state_q == StWait);
    step_valid  = busy && cond_true;
    step_idx    = idx_q;
    done        = (state_q == StDone);
    timeout_err = (state_q == StErr);
  end

endmodule

// File: tb/tb_cond_wait_seq.sv
// Directed bench for cond_wait_seq: vector table plus reset/timeout sequences.
module tb_cond_wait_seq;

  localparam int unsigned W = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam logic signed [31:0] MAXP = 32'sh7fffffff;

  logic                clk = 1'b0;
  logic                rst;
  logic                upd_valid;
  logic [1:0]          upd_sel;
  logic signed [W-1:0] upd_data;
  logic                start;
  logic                busy, step_valid, done, timeout_err;
  logic [2:0]          step_idx;
  logic signed [W-1:0] a_q, b_q, c_q;

  int n_app  = 0;
  int n_miss = 0;

  cond_wait_seq #(
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_sel     (upd_sel),
    .upd_data    (upd_data),
    .start       (start),
    .busy        (busy),
    .step_valid  (step_valid),
    .step_idx    (step_idx),
    .done        (done),
    .timeout_err (timeout_err),
    .a_q         (a_q),
    .b_q         (b_q),
    .c_q         (c_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               st;
    logic               wv;
    logic [1:0]         ws;
    logic signed [31:0] wd;
    logic               e_sv;
    logic [2:0]         e_idx;
    logic               e_busy;
    logic               e_done;
    logic               e_err;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic st, input logic wv, input logic [1:0] ws,
                              input logic signed [31:0] wd, input logic sv,
                              input logic [2:0] idx, input logic bz, input logic dn,
                              input logic er);
    vec_t v;
    v.st = st; v.wv = wv; v.ws = ws; v.wd = wd;
    v.e_sv = sv; v.e_idx = idx; v.e_busy = bz; v.e_done = dn; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_app++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic wv, input logic [1:0] ws,
                       input logic signed [31:0] wd);
    start     = st;
    upd_valid = wv;
    upd_sel   = ws;
    upd_data  = wd;
  endtask

  task automatic chk_outs(input string tag, input logic sv, input logic [2:0] idx,
                          input logic bz, input logic dn, input logic er);
    chk({tag, " step_valid"}, 32'(step_valid), 32'(sv));
    chk({tag, " step_idx"}, 32'(step_idx), 32'(idx));
    chk({tag, " busy"}, 32'(busy), 32'(bz));
    chk({tag, " done"}, 32'(done), 32'(dn));
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'(er));
  endtask

  // Called at a negedge: asserts rst mid-cycle and checks outputs clear at once.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk_outs(tag, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk({tag, " a_q"}, a_q, 32'd0);
    chk({tag, " b_q"}, b_q, 32'd0);
    chk({tag, " c_q"}, c_q, 32'd0);
    drive(1'b0, 1'b0, 2'd0, 32'sd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Canonical sequence: a=1,a=2,a=0,a=2,b=2,a=1,c=3,c=4,b=5.
    tbl[0]  = mk(1, 0, 0, 0,     0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1,     0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 2,     0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,     1, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0,     0, 1, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,     1, 1, 1, 0, 0);
    tbl[6]  = mk(0, 1, 0, 2,     1, 2, 1, 0, 0);
    tbl[7]  = mk(0, 1, 1, 2,     1, 3, 1, 0, 0);
    tbl[8]  = mk(0, 1, 0, 1,     0, 4, 1, 0, 0);
    tbl[9]  = mk(0, 1, 2, 3,     1, 4, 1, 0, 0);
    tbl[10] = mk(0, 1, 2, 4,     0, 5, 1, 0, 0);
    tbl[11] = mk(0, 1, 1, 5,     1, 5, 1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,     1, 6, 1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,     0, 6, 0, 1, 0);
    // Preset a=2 then restart: step 0 releases with no write; busy start ignored.
    tbl[14] = mk(0, 1, 0, 2,     0, 6, 0, 1, 0);
    tbl[15] = mk(1, 0, 0, 0,     0, 6, 0, 1, 0);
    tbl[16] = mk(1, 0, 0, 0,     1, 0, 1, 0, 0);
    tbl[17] = mk(0, 1, 0, 0,     0, 1, 1, 0, 0);
    tbl[18] = mk(0, 0, 0, 0,     1, 1, 1, 0, 0);
    tbl[19] = mk(0, 1, 0, 2,     1, 2, 1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0,     1, 3, 1, 0, 0);
    // Overflow at step 5: a=b=MAX, c=0 must not release.
    tbl[21] = mk(0, 1, 0, MAXP,  1, 4, 1, 0, 0);
    tbl[22] = mk(0, 1, 1, MAXP,  0, 5, 1, 0, 0);
    tbl[23] = mk(0, 1, 2, 0,     0, 5, 1, 0, 0);
    tbl[24] = mk(0, 1, 3, 7,     0, 5, 1, 0, 0);
    tbl[25] = mk(0, 0, 0, 0,     0, 5, 1, 0, 0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 32'sd0);
    @(posedge clk);
    @(negedge clk);
    chk_outs("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset a_q", a_q, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i].st, tbl[i].wv, tbl[i].ws, tbl[i].wd);
      chk_outs($sformatf("vec%0d", i), tbl[i].e_sv, tbl[i].e_idx, tbl[i].e_busy,
               tbl[i].e_done, tbl[i].e_err);
    end
    chk("ovf a_q", a_q, MAXP);
    chk("ovf b_q", b_q, MAXP);
    chk("sel3 ignored c_q", c_q, 32'd0);

    async_reset("rst step5");

    // Timeout: step 0 never true with a=0.
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 32'sd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0, 32'sd0);
      chk($sformatf("to cyc%0d busy", i), 32'(busy), 32'd1);
      chk($sformatf("to cyc%0d err", i), 32'(timeout_err), 32'd0);
    end
    @(negedge clk);
    chk_outs("timeout", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 2'd0, 32'sd0);
    @(negedge clk);
    chk_outs("restart", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Walk to step 3, then reset mid-step.
    drive(1'b0, 1'b1, 2'd0, 32'sd2);
    @(negedge clk);
    chk_outs("s3 walk0", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 32'sd0);
    @(negedge clk);
    chk_outs("s3 walk1", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 2'd0, 32'sd0);
    @(negedge clk);
    chk_outs("s3 walk2", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd0, 32'sd5);
    @(negedge clk);
    chk_outs("s3 hold", 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    async_reset("rst step3");

    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 32'sd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 32'sd0);
    chk_outs("post-rst start", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("post-rst a_q", a_q, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_miss);
    $finish;
  end

endmodule
